// File: rtl/adder_multicycle_nbit_if.sv
// Operand/result bundle for adder_multicycle_nbit: the operand source is the master,
// the adder is the slave.
interface adder_multicycle_nbit_if #(
    parameter int BIT_WIDTH = 32
);
    logic                 start;
    logic [BIT_WIDTH-1:0] a;
    logic [BIT_WIDTH-1:0] b;
    logic                 carry_in;
    logic                 signed_mode;
    logic                 busy;
    logic                 done;
    logic [BIT_WIDTH-1:0] sum;
    logic                 carry_out;
    logic                 overflow;
    logic                 error;

    modport master (
        output start, a, b, carry_in, signed_mode,
        input  busy, done, sum, carry_out, overflow, error
    );

    modport slave (
        input  start, a, b, carry_in, signed_mode,
        output busy, done, sum, carry_out, overflow, error
    );
endinterface

// File: rtl/adder_multicycle_nbit.sv
// Multi-cycle a+b+carry_in adder, one CHUNK_WIDTH slice per clock, with start/busy/done handshake.
// Define ADDER_MULTICYCLE_ERROR_DETECT_EN to add a full-width reference adder driving error.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | adding slice idx_q each clock (busy)
// DONE  | results just registered, done pulse; start here begins the next op
module adder_multicycle_nbit #(
    parameter int BIT_WIDTH   = 32,
    parameter int CHUNK_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   n_rst,
    adder_multicycle_nbit_if.slave bus
);
    localparam int NCHUNK = BIT_WIDTH / CHUNK_WIDTH;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);
    localparam int MSB = BIT_WIDTH - 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state_q, state_d;
    logic   capture, step, finish;

    logic [BIT_WIDTH-1:0] a_q, b_q, work_q, sum_q;
    logic                 sm_q, carry_q, cout_q, ovf_q;
    logic [IDXW-1:0]      idx_q;

    int unsigned          lsb;
    logic [CHUNK_WIDTH-1:0] slice_a, slice_b;
    logic [CHUNK_WIDTH:0]   slice_r;
    logic [BIT_WIDTH-1:0]   work_full;
    logic                   ovf_d;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    capture = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (idx_q == LAST_IDX) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    capture = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Working sum with the current slice merged in, so the final edge can register it directly.
    always_comb begin
        lsb       = int'(idx_q) * CHUNK_WIDTH;
        slice_a   = a_q[lsb +: CHUNK_WIDTH];
        slice_b   = b_q[lsb +: CHUNK_WIDTH];
        slice_r   = {1'b0, slice_a} + {1'b0, slice_b} + {{CHUNK_WIDTH{1'b0}}, carry_q};
        work_full = work_q;
        work_full[lsb +: CHUNK_WIDTH] = slice_r[CHUNK_WIDTH-1:0];
        if (sm_q) ovf_d = (a_q[MSB] == b_q[MSB]) && (work_full[MSB] != a_q[MSB]);
        else      ovf_d = slice_r[CHUNK_WIDTH];
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sm_q    <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (capture) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            sm_q    <= bus.signed_mode;
            carry_q <= bus.carry_in;
            idx_q   <= '0;
        end else if (step) begin
            work_q  <= work_full;
            carry_q <= slice_r[CHUNK_WIDTH];
            idx_q   <= idx_q + IDXW'(1);
            if (finish) begin
                sum_q  <= work_full;
                cout_q <= slice_r[CHUNK_WIDTH];
                ovf_q  <= ovf_d;
            end
        end
    end

`ifdef ADDER_MULTICYCLE_ERROR_DETECT_EN
    logic                 cin_q, err_q;
    logic [BIT_WIDTH:0]   ref_sum;

    assign ref_sum = {1'b0, a_q} + {1'b0, b_q} + {{BIT_WIDTH{1'b0}}, cin_q};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cin_q <= 1'b0;
            err_q <= 1'b0;
        end else if (capture) begin
            cin_q <= bus.carry_in;
        end else if (finish) begin
            err_q <= ({slice_r[CHUNK_WIDTH], work_full} != ref_sum);
        end
    end

    assign bus.error = err_q;
`else
    assign bus.error = 1'b0;
`endif

    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.carry_out = cout_q;
    assign bus.overflow  = ovf_q;
endmodule
